// File: rtl/light_sel_sequencer.sv
// Prescaled 0..MAX_SEL selector with run/pause/stop and preset; optional count-down via LIGHT_SEQ_REVERSE_EN.
// Latency: start sampled at edge t gives busy after t; first step visible after edge t+CLK_DIV.
// Backpressure: load_ready is low in RUN; the requester holds load_valid until IDLE or PAUSE.
module light_sel_sequencer #(
  parameter int CLK_DIV = 50_000_000,
  parameter int MAX_SEL = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       load_valid,
  input  logic [5:0] load_value,
`ifdef LIGHT_SEQ_REVERSE_EN
  input  logic       dir,
`endif
  output logic       load_ready,
  output logic [5:0] sel,
  output logic       step_pulse,
  output logic       wrap,
  output logic       busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [5:0]    SEL_MAX  = 6'(MAX_SEL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [5:0]    sel_nxt;
  logic          step_nxt, wrap_nxt, do_step, down;

`ifdef LIGHT_SEQ_REVERSE_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    sel_nxt   = sel;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    do_step   = 1'b0;

    // stop always has priority over start and over a terminal prescaler
    case (state)
      IDLE: begin
        pre_nxt = '0;
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (pre == PRE_LAST) begin
          pre_nxt = '0;
          do_step = 1'b1;
        end else begin
          pre_nxt = pre + PW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_step) begin
      step_nxt = 1'b1;
      if (down) begin
        if (sel == 6'd0) begin
          sel_nxt  = SEL_MAX;
          wrap_nxt = 1'b1;
        end else begin
          sel_nxt = sel - 6'd1;
        end
      end else begin
        if (sel == SEL_MAX) begin
          sel_nxt  = 6'd0;
          wrap_nxt = 1'b1;
        end else begin
          sel_nxt = sel + 6'd1;
        end
      end
    end

    // load only happens outside RUN, so it never collides with a step
    if (load_valid && load_ready) begin
      sel_nxt = (load_value > SEL_MAX) ? SEL_MAX : load_value;
      pre_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre        <= '0;
      sel        <= 6'd0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      sel        <= sel_nxt;
      step_pulse <= step_nxt;
      wrap       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_light_sel_sequencer.sv
// Scoreboard bench for light_sel_sequencer with CLK_DIV=4, MAX_SEL=59.
// Expected steps (value, wrap, cycle) are queued at stimulus time and popped on step_pulse.
module tb_light_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load_valid = 1'b0;
  logic [5:0] load_value = 6'd0;
  logic       dir = 1'b0;
  logic       load_ready;
  logic [5:0] sel;
  logic       step_pulse;
  logic       wrap;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int sel;
    int wrap;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  light_sel_sequencer #(.CLK_DIV(4), .MAX_SEL(59)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .load_valid (load_valid),
    .load_value (load_value),
`ifdef LIGHT_SEQ_REVERSE_EN
    .dir        (dir),
`endif
    .load_ready (load_ready),
    .sel        (sel),
    .step_pulse (step_pulse),
    .wrap       (wrap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dc: cycles from now until the step is visible
  task automatic expect_step(input int s, input int w, input int dc);
    exp_t e;
    e.sel  = s;
    e.wrap = w;
    e.cyc  = cyc + dc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic stop_to_idle();
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_ready", load_ready, 1);
  endtask

  always @(negedge clk) begin
    if (step_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", step_pulse, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_sel", sel, e.sel);
        check("step_wrap", wrap, e.wrap);
        check("step_cycle", cyc, e.cyc);
      end
    end else if (wrap) begin
      check("wrap_alone", wrap, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_sel", sel, 0);
    check("rst_step", step_pulse, 0);
    check("rst_wrap", wrap, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);

    // basic run: 0->1 after 4 RUN cycles, then 1->2
    expect_step(1, 0, 5);
    expect_step(2, 0, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", busy, 1);
    check("run_ready", load_ready, 0);
    drain("run_drain");
    stop_to_idle();

    // load 58 then run through the wrap
    load_valid = 1'b1;
    load_value = 6'd58;
    tick();
    load_valid = 1'b0;
    check("load58_sel", sel, 58);
    check("load58_nostep", step_pulse, 0);
    expect_step(59, 0, 5);
    expect_step(0, 1, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("wrap_drain");
    stop_to_idle();

    // pause with pre=2, resume after two cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pause_busy", busy, 0);
    check("pause_ready", load_ready, 1);
    tick();
    tick();
    check("pause_sel", sel, 0);
    expect_step(1, 0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("resume_drain");
    stop_to_idle();

    // from IDLE pre was cleared: full 4 cycles
    expect_step(2, 0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("fresh_drain");

    // load during RUN is held off, then lands saturated in PAUSE
    load_valid = 1'b1;
    load_value = 6'd63;
    check("run_load_ready", load_ready, 0);
    tick();
    check("run_load_sel", sel, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pause2_busy", busy, 0);
    check("pause2_sel", sel, 2);
    tick();
    load_valid = 1'b0;
    check("sat_sel", sel, 59);
    check("sat_nostep", step_pulse, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("p2i_busy", busy, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("both_busy", busy, 0);
    tick();
    check("both_busy2", busy, 0);
    check("both_sel", sel, 59);

    // reset at the terminal prescaler value suppresses the step
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_term_sel", sel, 59);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_sel", sel, 0);
    check("mrst_step", step_pulse, 0);
    check("mrst_wrap", wrap, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", load_ready, 1);
    tick();
    tick();
    check("mrst_idle", busy, 0);

`ifdef LIGHT_SEQ_REVERSE_EN
    dir = 1'b1;
    expect_step(59, 1, 5);
    expect_step(58, 0, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("rev_drain");
    stop_to_idle();
    dir = 1'b0;
`endif

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
